// File: rtl/load_store_unit.sv
// RV32I load/store sequencer for a single-port, word-wide data memory.
// Sub-word stores use read-modify-write because the bus only writes whole words.
module load_store_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, CAP, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [15:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wd_q, mem_wd_d;

    logic        illegal;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged_word;

    assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) ||
                     (req_store && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));

    assign misaligned = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

    // Little-endian lane selection from the word currently on the bus.
    assign byte_lane = mem_rd[{off_q, 3'b000} +: 8];
    assign half_lane = mem_rd[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_ext = {24'h000000, byte_lane};
            3'b101:  load_ext = {16'h0000, half_lane};
            default: load_ext = mem_rd;
        endcase
    end

    // Only SB (000) and SH (001) ever reach MERGE, so funct3 bit 0 picks the lane width.
    always_comb begin
        merged_word = mem_rd;
        if (funct3_q[0]) begin
            merged_word[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end else begin
            merged_word[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        store_d      = store_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wd_d     = mem_wd_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d        = req_addr[1:0];
                    funct3_d     = req_funct3;
                    store_d      = req_store;
                    wdata_d      = req_wdata[15:0];
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    if (illegal || misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_store && (req_funct3 == 3'b010)) begin
                            state_d  = WR;
                            mem_we_d = 1'b1;
                            mem_wd_d = req_wdata;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                state_d = store_q ? MERGE : CAP;
            end
            MERGE: begin
                state_d  = WR;
                mem_we_d = 1'b1;
                mem_wd_d = merged_word;
            end
            CAP: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d    = IDLE;
                resp_err_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            off_q        <= 2'b00;
            funct3_q     <= 3'b000;
            store_q      <= 1'b0;
            wdata_q      <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_wd_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            store_q      <= store_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wd     = mem_wd_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences RV32I loads and stores from the core's execute stage onto the single-port, word-wide data memory bus. It sits directly upstream of the memory interface. Its jobs:
- Word-align addresses.
- Sign- or zero-extend sub-word loads.
- Run a read-modify-write for byte and halfword stores, because the memory bus has only a whole-word write enable.
- Reject misaligned or illegal accesses without touching memory.

## Interface
Parameters: none. Data and address widths are fixed at 32 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents an access
- req_ready  out  1  LSU can accept; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte or halfword used for sub-word stores
- resp_valid  out  1  one-cycle pulse; access complete
- resp_err  out  1  valid with resp_valid; misaligned or illegal funct3
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- mem_addr  out  32  word-aligned address to memory (bits [1:0] = 0)
- mem_we  out  1  word write enable
- mem_wd  out  32  write data to memory
- mem_rd  in  32  read data; valid in the cycle after mem_addr is first driven and while it is held

## Operation
- States: IDLE, RD, MERGE, CAP, WR, RESP.
- IDLE, acceptance:
  - req_ready = 1.
  - On req_valid, latch addr, funct3, store flag and wdata.
- IDLE, legality check (performed in the acceptance cycle):
  - Illegal funct3 is 011, 110 or 111, or 100/101 with req_store = 1.
  - Misaligned is H with addr[0] = 1, or W with addr[1:0] ≠ 0.
  - Either condition: go to RESP with err = 1. No memory cycle is issued.
- Load: IDLE → RD → CAP → RESP.
  - RD drives mem_addr = {addr[31:2], 2'b00} with mem_we = 0.
  - CAP samples mem_rd, selects the lane, extends it, and registers the result into resp_rdata.
- Store word: IDLE → WR → RESP.
  - WR drives mem_wd = wdata and mem_we = 1 for exactly one cycle.
- Store byte/halfword: IDLE → RD → MERGE → WR → RESP.
  - MERGE samples mem_rd and replaces the selected lane with wdata[7:0] or wdata[15:0].
  - The merged word is registered into mem_wd.
- Lane selection is little-endian.
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword lane addr[1] occupies [15:0] or [31:16].
- Extension: B/H replicate the sign bit of the selected lane; BU/HU zero-fill.
- RESP:
  - resp_valid = 1 for one cycle; resp_err as decided.
  - resp_rdata holds the load result; it is 0 for stores and errors.
  - Next state is IDLE.
- No response backpressure; the core must accept resp in the RESP cycle.
- mem_addr holds its last value outside RD/MERGE/CAP/WR. mem_we = 0 in every state except WR.

## Timing
- Reset (rstn low, asynchronous):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err and mem_we = 0.
  - resp_rdata, mem_addr and mem_wd = 0.
  - All outputs are registered, so reset takes effect immediately, not at the next edge.
- Reset asserted mid-operation aborts the access: no response, and mem_we drops at once. A write in progress may or may not have been committed, depending on the clock edge already taken.
- Latency from the acceptance edge (cycle 0) to the resp_valid cycle:
  - load: 3
  - store word: 2
  - sub-word store: 4
  - error: 1
- Throughput: the next request is accepted the cycle after RESP (req_ready returns high). A request held across RESP is accepted in the following IDLE cycle.
- req_* inputs are ignored outside IDLE. Latched values are immune to later input changes.
- mem_addr is stable through RD→CAP and RD→MERGE→WR, so RMW read and write hit the same word.

## Test plan
- Reset → all outputs at reset values; req_ready = 1, mem_we = 0.
- Load:
  - Memory word at 0x0010_0004 = 0x80FF_7F01.
  - LB at 0x0010_0007 → resp_rdata 0xFFFF_FF80.
  - LBU at the same address → 0x0000_0080.
  - LH at 0x0010_0004 → 0x0000_7F01.
  - LW at 0x0010_0004 → 0x80FF_7F01.
  - Each response appears 3 cycles after acceptance.
- Sub-word store:
  - Word 0x1122_3344 at 0x0010_0008.
  - SB wdata 0xAB at 0x0010_0009 → exactly one cycle with mem_we = 1, mem_wd = 0x1122_AB44.
  - resp_valid comes 4 cycles after acceptance with resp_err = 0.
  - SH wdata 0xBEEF at 0x0010_000A → writes 0xBEEF_3344.
- Store word: SW 0xDEAD_BEEF at 0x0010_0010 → mem_we pulse in cycle 1 with mem_addr 0x0010_0010; resp_valid in cycle 2.
- Errors, each giving resp_valid with resp_err = 1 in cycle 1, mem_we never asserted, and resp_rdata = 0:
  - LW at 0x0010_0002
  - SH at 0x0010_0001
  - funct3 = 011
  - store with funct3 = 100
- Reset mid-RMW: drop rstn during MERGE → mem_we = 0, no resp_valid. After release, req_ready = 1 and a new LW completes normally.
